reminder_countdown: RTL and testbench

REMINDER_COUNTDOWN -- requirements
Module: reminder_countdown

---
 rtl/countdown_pkg.sv | 39 +++
 rtl/bcd_down_digit.sv | 39 +++
 rtl/reminder_countdown.sv | 146 ++++++++++++++
 tb/tb_reminder_countdown.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and limits for the HH:MM:SS reminder countdown.
// BCD time layout, FSM states and the set_time legality check.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_ALARM
  } state_e;

  typedef struct packed {
    logic [3:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } bcd_time_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  // Valid BCD digits compare correctly as plain binary.
  function automatic logic time_legal(
    input bcd_time_t  t,
    input logic [3:0] max_h1,
    input logic [7:0] max_hours
  );
    logic ok;
    ok = (t.s0 <= DIGIT_MAX) && (t.m0 <= DIGIT_MAX)
      && (t.h0 <= DIGIT_MAX) && (t.h1 <= DIGIT_MAX)
      && (t.s1 <= TENS_MAX)  && (t.m1 <= TENS_MAX)
      && (t.h1 <= max_h1)
      && ({t.h1, t.h0} <= max_hours);
    return ok;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with parallel load.
// Decrements on en & borrow_in; wraps from 0 to WRAP.
module bcd_down_digit #(
  parameter int WRAP = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (en && borrow_in) begin
      digit_d = (digit_q == 4'd0) ? 4'(WRAP) : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit      = digit_q;
  assign borrow_out = borrow_in && (digit_q == 4'd0);

endmodule

// File: rtl/reminder_countdown.sv
// Reminder countdown timer: preset, run/pause, alarm with ack/auto-reload.
// Count lives in a six-digit BCD borrow chain driven by the FSM below.
module reminder_countdown
  import countdown_pkg::*;
#(
  parameter int         MAX_H1    = 2,
  parameter logic [7:0] MAX_HOURS = 8'h23
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  input  logic        ack,
  input  logic        auto_reload,
  input  logic        set_valid,
  input  logic [23:0] set_time,
  output logic [23:0] count,
  output logic        running,
  output logic        alarm,
  output logic        expire,
  output logic        set_err
);

  state_e    state_q, state_d;
  bcd_time_t preset_q, preset_d;
  bcd_time_t count_q;
  bcd_time_t load_val;

  logic running_q, alarm_q, expire_q, set_err_q;
  logic expire_d, set_err_d;
  logic load_en, dec_en;
  logic count_zero, count_one, legal;
  logic [6:0] borrow;

  assign borrow[0]  = 1'b1;
  // Borrow out of the top digit means every digit is zero.
  assign count_zero = borrow[6];
  assign count_one  = (count_q == 24'h000001);
  assign legal = time_legal(set_time, 4'(MAX_H1), MAX_HOURS);

  always_comb begin
    state_d   = state_q;
    preset_d  = preset_q;
    load_en   = 1'b0;
    load_val  = preset_q;
    dec_en    = 1'b0;
    expire_d  = 1'b0;
    set_err_d = 1'b0;
    if (clear) begin
      load_en = 1'b1;
      state_d = ST_IDLE;
    end else if (set_valid && state_q != ST_RUN) begin
      if (legal) begin
        preset_d = set_time;
        load_en  = 1'b1;
        load_val = set_time;
        state_d  = ST_IDLE;
      end else begin
        set_err_d = 1'b1;
      end
    end else if (pause && state_q == ST_RUN) begin
      state_d = ST_PAUSED;
    end else if (start && (state_q == ST_IDLE ||
                           state_q == ST_PAUSED)) begin
      if (!count_zero) state_d = ST_RUN;
    end else if (ack && state_q == ST_ALARM) begin
      load_en = 1'b1;
      state_d = (auto_reload && preset_q != '0) ? ST_RUN : ST_IDLE;
    end else if (tick && state_q == ST_RUN) begin
      dec_en = 1'b1;
      if (count_one) begin
        state_d  = ST_ALARM;
        expire_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      preset_q  <= '0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
      expire_q  <= 1'b0;
      set_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      preset_q  <= preset_d;
      running_q <= (state_d == ST_RUN);
      alarm_q   <= (state_d == ST_ALARM);
      expire_q  <= expire_d;
      set_err_q <= set_err_d;
    end
  end

  bcd_down_digit #(.WRAP(9)) u_s0 (
    .clk(clk), .reset(reset), .load(load_en),
    .load_val(load_val.s0), .en(dec_en),
    .borrow_in(borrow[0]), .digit(count_q.s0),
    .borrow_out(borrow[1])
  );

  bcd_down_digit #(.WRAP(5)) u_s1 (
    .clk(clk), .reset(reset), .load(load_en),
    .load_val(load_val.s1), .en(dec_en),
    .borrow_in(borrow[1]), .digit(count_q.s1),
    .borrow_out(borrow[2])
  );

  bcd_down_digit #(.WRAP(9)) u_m0 (
    .clk(clk), .reset(reset), .load(load_en),
    .load_val(load_val.m0), .en(dec_en),
    .borrow_in(borrow[2]), .digit(count_q.m0),
    .borrow_out(borrow[3])
  );

  bcd_down_digit #(.WRAP(5)) u_m1 (
    .clk(clk), .reset(reset), .load(load_en),
    .load_val(load_val.m1), .en(dec_en),
    .borrow_in(borrow[3]), .digit(count_q.m1),
    .borrow_out(borrow[4])
  );

  bcd_down_digit #(.WRAP(9)) u_h0 (
    .clk(clk), .reset(reset), .load(load_en),
    .load_val(load_val.h0), .en(dec_en),
    .borrow_in(borrow[4]), .digit(count_q.h0),
    .borrow_out(borrow[5])
  );

  bcd_down_digit #(.WRAP(MAX_H1)) u_h1 (
    .clk(clk), .reset(reset), .load(load_en),
    .load_val(load_val.h1), .en(dec_en),
    .borrow_in(borrow[5]), .digit(count_q.h1),
    .borrow_out(borrow[6])
  );

  assign count   = count_q;
  assign running = running_q;
  assign alarm   = alarm_q;
  assign expire  = expire_q;
  assign set_err = set_err_q;

endmodule

// File: tb/tb_reminder_countdown.sv
// Directed self-checking bench for reminder_countdown.
// Outputs are sampled 1 time unit after each rising edge.
module tb_reminder_countdown;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        clear = 1'b0;
  logic        ack = 1'b0;
  logic        auto_reload = 1'b0;
  logic        set_valid = 1'b0;
  logic [23:0] set_time = '0;
  logic [23:0] count;
  logic        running, alarm, expire, set_err;

  int n_chk  = 0;
  int n_fail = 0;

  reminder_countdown dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .pause(pause), .clear(clear), .ack(ack),
    .auto_reload(auto_reload), .set_valid(set_valid),
    .set_time(set_time), .count(count), .running(running),
    .alarm(alarm), .expire(expire), .set_err(set_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [23:0] obs,
                     input logic [23:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic flags(input string tag, input logic r,
                       input logic a, input logic e,
                       input logic s);
    chk({tag, ".running"}, {23'd0, running}, {23'd0, r});
    chk({tag, ".alarm"},   {23'd0, alarm},   {23'd0, a});
    chk({tag, ".expire"},  {23'd0, expire},  {23'd0, e});
    chk({tag, ".set_err"}, {23'd0, set_err}, {23'd0, s});
  endtask

  task automatic do_set(input logic [23:0] t);
    set_time = t; set_valid = 1'b1; cyc(); set_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1; cyc(); tick = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1; cyc(); ack = 1'b0;
  endtask

  initial begin
    cyc(); cyc();
    chk("rst.count", count, 24'h000000);
    flags("rst", 0, 0, 0, 0);
    reset = 1'b1;
    cyc();

    // three-second run to alarm
    do_set(24'h000003);
    chk("t1.load", count, 24'h000003);
    do_start();
    flags("t1.start", 1, 0, 0, 0);
    do_tick();
    chk("t1.tick1", count, 24'h000002);
    do_tick();
    chk("t1.tick2", count, 24'h000001);
    chk("t1.noexp", {23'd0, expire}, 24'd0);
    do_tick();
    chk("t1.tick3", count, 24'h000000);
    flags("t1.alarm", 0, 1, 1, 0);
    cyc();
    flags("t1.hold", 0, 1, 0, 0);
    do_tick();
    chk("t1.alarm_tick", count, 24'h000000);
    do_clear();
    chk("t1.clear", count, 24'h000003);
    flags("t1.clear", 0, 0, 0, 0);

    // multi-digit borrow
    do_set(24'h010000);
    do_start();
    do_tick();
    chk("t2.borrow_h", count, 24'h005959);
    do_clear();
    do_set(24'h200000);
    do_start();
    do_tick();
    chk("t2.borrow_h1", count, 24'h195959);
    do_clear();
    chk("t2.clear", count, 24'h200000);

    // illegal set values
    do_set(24'h000700);
    chk("t3.load", count, 24'h000700);
    do_set(24'h006000);
    chk("t3.m1bad", count, 24'h000700);
    chk("t3.err", {23'd0, set_err}, 24'd1);
    cyc();
    chk("t3.errpulse", {23'd0, set_err}, 24'd0);
    do_set(24'h240000);
    chk("t3.hbad", {23'd0, set_err}, 24'd1);
    do_set(24'h00000a);
    chk("t3.s0bad", {23'd0, set_err}, 24'd1);
    chk("t3.keep", count, 24'h000700);

    // pause beats tick
    do_set(24'h000005);
    do_start();
    tick = 1'b1; pause = 1'b1; cyc();
    tick = 1'b0; pause = 1'b0;
    chk("t4.pause", count, 24'h000005);
    flags("t4.pause", 0, 0, 0, 0);
    do_tick();
    chk("t4.pticks", count, 24'h000005);
    do_start();
    do_tick();
    chk("t4.resume", count, 24'h000004);
    do_set(24'h000009);
    chk("t4.set_run", count, 24'h000004);
    flags("t4.set_run", 1, 0, 0, 0);
    do_clear();
    chk("t4.clear", count, 24'h000005);

    // ack with and without auto reload
    do_set(24'h000002);
    do_start();
    do_tick();
    do_tick();
    flags("t5.alarm", 0, 1, 1, 0);
    auto_reload = 1'b1;
    do_ack();
    chk("t5.reload", count, 24'h000002);
    flags("t5.reload", 1, 0, 0, 0);
    do_tick();
    do_tick();
    chk("t5.alarm2", {23'd0, alarm}, 24'd1);
    auto_reload = 1'b0;
    do_ack();
    chk("t5.noreload", count, 24'h000002);
    flags("t5.noreload", 0, 0, 0, 0);
    do_set(24'h000000);
    do_start();
    chk("t5.zero_start", {23'd0, running}, 24'd0);

    // reset mid-run
    do_set(24'h123456);
    do_start();
    chk("t6.run", {23'd0, running}, 24'd1);
    reset = 1'b0; tick = 1'b1; start = 1'b1; cyc();
    tick = 1'b0; start = 1'b0;
    chk("t6.rst", count, 24'h000000);
    flags("t6.rst", 0, 0, 0, 0);
    reset = 1'b1;
    do_start();
    chk("t6.idle", {23'd0, running}, 24'd0);
    do_clear();
    chk("t6.preset0", count, 24'h000000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
